// File: rtl/immgen_pkg.sv
// immgen_pkg: immediate-format select encodings and the pipeline entry type shared by the immediate generator
package immgen_pkg;
  localparam int XLEN_MAX = 64;
  localparam int TAG_W_MAX = 32;
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_U     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_B     = 3'b100;
  localparam logic [2:0] IMM_IU    = 3'b101;
  localparam logic [2:0] IMM_SHAMT = 3'b110;
  localparam logic [2:0] IMM_Z     = 3'b111;
  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    logic [XLEN_MAX-1:0]  target;
    logic [XLEN_MAX-1:0]  pc;
    logic [TAG_W_MAX-1:0] tag;
  } entry_t;
endpackage

// File: rtl/immgen_core.sv
// immgen_core: combinational RISC-V immediate decode to XLEN bits; IMMGEN_SHAMT_EN turns sel 110 into a zero-extended shamt, otherwise it decodes as I
module immgen_core
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;
  logic        unused_op;
  always_comb begin
    imm32 = sel == IMM_S  ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
          : sel == IMM_U  ? {instr[31:12], 12'b0}
          : sel == IMM_J  ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}
          : sel == IMM_B  ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}
          : sel == IMM_IU ? {20'b0, instr[31:20]}
          : sel == IMM_Z  ? 32'b0
`ifdef IMMGEN_SHAMT_EN
          : sel == IMM_SHAMT ? (XLEN == 64 ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]})
`endif
          : {{20{instr[31]}}, instr[31:20]};
  end
  // Zero-extended formats have bit 31 clear, so one sign extension serves every format.
  assign imm = XLEN'($signed(imm32));
  assign unused_op = ^instr[6:0];
endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: registered immediate/target generator with valid-ready skid buffer and sync flush (IMMGEN_SHAMT_EN selects shamt decode for sel 110)
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag
);
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  entry_t          in_e;
  entry_t          main_q;
  entry_t          skid_q;
  logic            main_v;
  logic            skid_v;
  logic            acc;
  logic            pop;
  logic            unused_main;
  immgen_core #(.XLEN(XLEN)) u_core (
    .instr(in_instr),
    .sel  (in_sel),
    .imm  (imm)
  );
  assign target = in_pc + imm;
  assign in_e = '{imm: XLEN_MAX'(imm), target: XLEN_MAX'(target), pc: XLEN_MAX'(in_pc), tag: TAG_W_MAX'(in_tag)};
  assign in_ready = !skid_v;
  assign acc = in_valid && in_ready;
  assign pop = main_v && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      // A full skid means in_ready was low, so nothing can be accepted on this edge.
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else begin
        main_v <= acc;
        if (acc) main_q <= in_e;
      end
    end else if (main_v) begin
      if (acc) begin
        skid_q <= in_e;
        skid_v <= 1'b1;
      end
    end else if (acc) begin
      main_q <= in_e;
      main_v <= 1'b1;
    end
  end
  assign out_valid   = main_v;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_target  = main_q.target[XLEN-1:0];
  assign out_pc      = main_q.pc[XLEN-1:0];
  assign out_tag     = main_q.tag[TAG_W-1:0];
  assign unused_main = ^main_q;
endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: directed self-checking bench for immgen_pipe at XLEN 32 and 64
module tb_immgen_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        out_ready = 1;
  logic [31:0] in_instr = 0;
  logic [31:0] in_pc = 0;
  logic [63:0] in_pc64 = 0;
  logic [2:0]  in_sel = 0;
  logic [4:0]  in_tag = 0;
  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] out_imm, out_target, out_pc;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [4:0]  out_tag, out_tag64;
  int checks = 0;
  int errors = 0;
  logic [31:0] t_instr [11];
  logic [2:0]  t_sel   [11];
  logic [31:0] t_pc    [11];
  logic [31:0] t_imm   [11];
  logic [31:0] t_tgt   [11];
  logic [63:0] t_imm64 [11];
  logic [63:0] t_tgt64 [11];
  immgen_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_pc(out_pc), .out_tag(out_tag)
  );
  immgen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_target(out_target64), .out_pc(out_pc64), .out_tag(out_tag64)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] addi(input int k);
    return (32'(k) << 20) | 32'h93;
  endfunction
  task automatic drive(input logic [31:0] instr, input logic [2:0] sel, input logic [31:0] pc, input logic [4:0] tag);
    @(negedge clk);
    in_valid = 1;
    in_instr = instr;
    in_sel = sel;
    in_pc = pc;
    in_pc64 = 64'(pc);
    in_tag = tag;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, in_ready, out_imm, out_target, out_pc, out_tag} !== {1'b0, 1'b1, 101'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b imm=%h tgt=%h pc=%h tag=%h, need v=0 rdy=1 rest 0", out_valid, in_ready, out_imm, out_target, out_pc, out_tag);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL after_reset: got v=%b rdy=%b, need v=0 rdy=1", out_valid, in_ready);
    end
  endtask
  task automatic test_formats;
    t_instr = '{32'hFFF00093, 32'hFFF00093, 32'hFE000EE3, 32'hFE000EE3, 32'h800000B7, 32'h123450B7,
                32'hFE112C23, 32'hFFDFF06F, 32'hFFFFFFFF, 32'h01F0D093, 32'hFFF0D093};
    t_sel   = '{3'd0, 3'd5, 3'd4, 3'd4, 3'd2, 3'd2, 3'd1, 3'd3, 3'd7, 3'd6, 3'd6};
    t_pc    = '{32'h0, 32'h10, 32'h100, 32'h0, 32'h0, 32'h0, 32'h40, 32'h200, 32'h1234, 32'h0, 32'h8};
    t_imm   = '{32'hFFFFFFFF, 32'h00000FFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000, 32'h12345000,
                32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h1F, 32'h0};
    t_tgt   = '{32'hFFFFFFFF, 32'h0000100F, 32'h000000FC, 32'hFFFFFFFC, 32'h80000000, 32'h12345000,
                32'h00000038, 32'h000001FC, 32'h1234, 32'h1F, 32'h0};
    t_imm64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
                64'h12345000, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h1F, 64'h0};
    t_tgt64 = '{64'hFFFFFFFFFFFFFFFF, 64'h100F, 64'hFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
                64'h12345000, 64'h38, 64'h1FC, 64'h1234, 64'h1F, 64'h0};
`ifdef IMMGEN_SHAMT_EN
    t_imm[10] = 32'h1F;
    t_tgt[10] = 32'h27;
    t_imm64[10] = 64'h3F;
    t_tgt64[10] = 64'h47;
`else
    t_imm[10] = 32'hFFFFFFFF;
    t_tgt[10] = 32'h7;
    t_imm64[10] = 64'hFFFFFFFFFFFFFFFF;
    t_tgt64[10] = 64'h7;
`endif
    for (int i = 0; i < 11; i++) begin
      drive(t_instr[i], t_sel[i], t_pc[i], 5'(i + 1));
      checks++;
      if ({out_valid, out_imm, out_target, out_pc, out_tag} !== {1'b1, t_imm[i], t_tgt[i], t_pc[i], 5'(i + 1)}) begin
        errors++;
        $display("FAIL fmt32[%0d]: got v=%b imm=%h tgt=%h pc=%h tag=%0d, need v=1 imm=%h tgt=%h pc=%h tag=%0d",
                 i, out_valid, out_imm, out_target, out_pc, out_tag, t_imm[i], t_tgt[i], t_pc[i], i + 1);
      end
      checks++;
      if ({out_valid64, out_imm64, out_target64} !== {1'b1, t_imm64[i], t_tgt64[i]}) begin
        errors++;
        $display("FAIL fmt64[%0d]: got v=%b imm=%h tgt=%h, need v=1 imm=%h tgt=%h",
                 i, out_valid64, out_imm64, out_target64, t_imm64[i], t_tgt64[i]);
      end
    end
  endtask
  task automatic test_back_to_back;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got v=%b, need 0", out_valid);
    end
    out_ready = 0;
    drive(addi(1), 3'd0, 32'h0, 5'd1);
    checks++;
    if ({out_valid, out_imm, in_ready} !== {1'b1, 32'd1, 1'b1}) begin
      errors++;
      $display("FAIL bp_a: got v=%b imm=%h rdy=%b, need v=1 imm=1 rdy=1", out_valid, out_imm, in_ready);
    end
    drive(addi(2), 3'd0, 32'h0, 5'd2);
    checks++;
    if ({out_imm, out_tag, in_ready} !== {32'd1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_b: got imm=%h tag=%0d rdy=%b, need imm=1 tag=1 rdy=0", out_imm, out_tag, in_ready);
    end
    @(negedge clk);
    in_valid = 1;
    in_instr = addi(3);
    in_tag = 5'd3;
    @(posedge clk);
    #1;
    checks++;
    if ({out_imm, out_tag, in_ready} !== {32'd1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_c_held: got imm=%h tag=%0d rdy=%b, need imm=1 tag=1 rdy=0", out_imm, out_tag, in_ready);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_imm, out_tag, in_ready} !== {1'b1, 32'd2, 5'd2, 1'b1}) begin
      errors++;
      $display("FAIL bp_out_b: got v=%b imm=%h tag=%0d rdy=%b, need v=1 imm=2 tag=2 rdy=1", out_valid, out_imm, out_tag, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    checks++;
    if ({out_valid, out_imm, out_tag} !== {1'b1, 32'd3, 5'd3}) begin
      errors++;
      $display("FAIL bp_out_c: got v=%b imm=%h tag=%0d, need v=1 imm=3 tag=3", out_valid, out_imm, out_tag);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got v=%b, need 0", out_valid);
    end
  endtask
  task automatic test_flush;
    out_ready = 0;
    drive(addi(1), 3'd0, 32'h0, 5'd1);
    drive(addi(2), 3'd0, 32'h0, 5'd2);
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL fl_full: got v=%b rdy=%b, need v=1 rdy=0", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1;
    in_instr = addi(4);
    in_tag = 5'd4;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    checks++;
    if ({out_valid, in_ready, out_valid64} !== 3'b010) begin
      errors++;
      $display("FAIL fl_clear: got v=%b rdy=%b v64=%b, need v=0 rdy=1 v64=0", out_valid, in_ready, out_valid64);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fl_no_ghost: got v=%b imm=%h, need v=0", out_valid, out_imm);
    end
    drive(addi(5), 3'd0, 32'h0, 5'd5);
    checks++;
    if ({out_valid, out_imm, out_tag} !== {1'b1, 32'd5, 5'd5}) begin
      errors++;
      $display("FAIL fl_resume: got v=%b imm=%h tag=%0d, need v=1 imm=5 tag=5", out_valid, out_imm, out_tag);
    end
  endtask
  task automatic test_async_reset;
    out_ready = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_imm} !== {1'b1, 32'd5}) begin
      errors++;
      $display("FAIL ar_hold: got v=%b imm=%h, need v=1 imm=5", out_valid, out_imm);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_imm, out_target, out_pc, out_tag} !== {1'b0, 1'b1, 101'b0}) begin
      errors++;
      $display("FAIL ar_async: got v=%b rdy=%b imm=%h tgt=%h pc=%h tag=%h, need v=0 rdy=1 rest 0", out_valid, in_ready, out_imm, out_target, out_pc, out_tag);
    end
    checks++;
    if ({out_valid64, out_imm64} !== 65'b0) begin
      errors++;
      $display("FAIL ar_async64: got v=%b imm=%h, need 0", out_valid64, out_imm64);
    end
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ar_after: got v=%b rdy=%b, need v=0 rdy=1", out_valid, in_ready);
    end
  endtask
  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
